// File: rtl/imm_extend_unit.sv
// Immediate extension unit: sign/zero/upper extension of one word, or a
// two-word CONCAT, behind a valid/ready handshake on both sides.
module imm_extend_unit #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_word,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             busy
);

    if (OUT_W < 2*IN_W) begin : g_width_check
        $error("imm_extend_unit: OUT_W must be at least 2*IN_W");
    end

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_HI_HELD = 1'b1
    } state_t;

    localparam logic [1:0] MODE_SIGN   = 2'b00;
    localparam logic [1:0] MODE_ZERO   = 2'b01;
    localparam logic [1:0] MODE_UPPER  = 2'b10;
    localparam logic [1:0] MODE_CONCAT = 2'b11;

    function automatic logic [OUT_W-1:0] ext_sign(input logic [IN_W-1:0] w);
        return OUT_W'($signed(w));
    endfunction

    function automatic logic [OUT_W-1:0] ext_zero(input logic [IN_W-1:0] w);
        return OUT_W'(w);
    endfunction

    // Sign-extends a {hi, lo} pair from its top bit; UPPER is a pair with lo = 0.
    function automatic logic [OUT_W-1:0] ext_pair(input logic [IN_W-1:0] hi,
                                                  input logic [IN_W-1:0] lo);
        logic [2*IN_W-1:0] p;
        p = {hi, lo};
        return OUT_W'($signed(p));
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IN_W-1:0]    r_hi;
    logic [OUT_W-1:0]   r_out_data;
    logic               r_out_valid;
    logic               w_accept;
    logic               w_load_result;
    logic               w_load_hi;
    logic [OUT_W-1:0]   w_result;

    assign in_ready  = (!r_out_valid || out_ready) && !flush;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else if (w_accept) begin
            case (r_state)
                S_IDLE:    w_state_nxt = (in_mode == MODE_CONCAT) ? S_HI_HELD : S_IDLE;
                S_HI_HELD: w_state_nxt = S_IDLE;
                default:   w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy          = (r_state == S_HI_HELD);
        w_load_hi     = w_accept && (r_state == S_IDLE) && (in_mode == MODE_CONCAT);
        w_load_result = w_accept && !w_load_hi;
        w_result      = ext_sign(in_word);
        if (r_state == S_HI_HELD) begin
            w_result = ext_pair(r_hi, in_word);
        end else begin
            case (in_mode)
                MODE_SIGN:  w_result = ext_sign(in_word);
                MODE_ZERO:  w_result = ext_zero(in_word);
                MODE_UPPER: w_result = ext_pair(in_word, {IN_W{1'b0}});
                default:    w_result = ext_sign(in_word);
            endcase
        end
    end

    // A high-word capture can only happen when the output slot is free or
    // draining this cycle, so clearing out_valid there is always correct.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_hi        <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_hi        <= '0;
        end else if (w_load_result) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_result;
        end else if (w_load_hi) begin
            r_out_valid <= 1'b0;
            r_hi        <= in_word;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_imm_extend_unit.sv
// Directed bench for imm_extend_unit (IN_W=16, OUT_W=32) with hand-computed
// expected values.
module tb_imm_extend_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_word;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    imm_extend_unit #(.IN_W(16), .OUT_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [15:0] w);
        in_valid = v;
        in_mode  = m;
        in_word  = w;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 2'b00, 16'h0000);
        #3;
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_val("rst_busy",  32'(busy), 32'd0);
        check_val("rst_data",  out_data, 32'h0);
        tick();
        rst = 1'b1;
        check_val("ready_after_rst", 32'(in_ready), 32'd1);

        out_ready = 1'b1;
        drive(1'b1, 2'b00, 16'h8001);
        tick();
        check_val("sign_valid", 32'(out_valid), 32'd1);
        check_val("sign_data", out_data, 32'hFFFF8001);
        drive(1'b1, 2'b01, 16'h8001);
        tick();
        check_val("zero_data", out_data, 32'h00008001);
        check_val("zero_valid", 32'(out_valid), 32'd1);
        drive(1'b1, 2'b10, 16'h1234);
        tick();
        check_val("upper_data", out_data, 32'h12340000);
        drive(1'b1, 2'b10, 16'h8000);
        tick();
        check_val("upper_neg", out_data, 32'h80000000);

        // CONCAT high word while the previous result drains
        drive(1'b1, 2'b11, 16'hDEAD);
        tick();
        check_val("cat_hi_valid", 32'(out_valid), 32'd0);
        check_val("cat_hi_busy", 32'(busy), 32'd1);
        drive(1'b0, 2'b00, 16'h0000);
        tick();
        check_val("cat_hold_busy", 32'(busy), 32'd1);
        check_val("cat_hold_valid", 32'(out_valid), 32'd0);
        drive(1'b1, 2'b01, 16'hBEEF);
        tick();
        check_val("cat_data", out_data, 32'hDEADBEEF);
        check_val("cat_valid", 32'(out_valid), 32'd1);
        check_val("cat_busy", 32'(busy), 32'd0);
        drive(1'b0, 2'b00, 16'h0000);
        tick();
        check_val("drain_valid", 32'(out_valid), 32'd0);

        // Back-pressure
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 16'h7FFF);
        tick();
        check_val("bp_data0", out_data, 32'h00007FFF);
        drive(1'b1, 2'b00, 16'h1234);
        for (int i = 0; i < 3; i++) begin
            check_val("bp_ready", 32'(in_ready), 32'd0);
            tick();
            check_val("bp_valid", 32'(out_valid), 32'd1);
            check_val("bp_stable", out_data, 32'h00007FFF);
        end
        out_ready = 1'b1;
        drive(1'b1, 2'b00, 16'h0005);
        #1;
        check_val("bp_ready_rise", 32'(in_ready), 32'd1);
        tick();
        check_val("bp_new_data", out_data, 32'h00000005);
        check_val("bp_new_valid", 32'(out_valid), 32'd1);
        drive(1'b0, 2'b00, 16'h0000);
        tick();
        check_val("bp_drain", 32'(out_valid), 32'd0);

        // Flush while holding a high word
        drive(1'b1, 2'b11, 16'hAAAA);
        tick();
        check_val("fl_busy_pre", 32'(busy), 32'd1);
        drive(1'b1, 2'b00, 16'h5555);
        flush = 1'b1;
        #1;
        check_val("fl_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        check_val("fl_busy", 32'(busy), 32'd0);
        check_val("fl_valid", 32'(out_valid), 32'd0);
        drive(1'b1, 2'b01, 16'h0001);
        tick();
        check_val("fl_after_data", out_data, 32'h00000001);
        check_val("fl_after_valid", 32'(out_valid), 32'd1);
        // Flush with a pending result keeps out_data
        out_ready = 1'b0;
        drive(1'b0, 2'b00, 16'h0000);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_val("fl_pend_valid", 32'(out_valid), 32'd0);
        check_val("fl_pend_data", out_data, 32'h00000001);

        // Async reset in HI_HELD
        out_ready = 1'b1;
        drive(1'b1, 2'b11, 16'h1111);
        tick();
        drive(1'b0, 2'b00, 16'h0000);
        check_val("ar_hi_busy_pre", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check_val("ar_hi_busy", 32'(busy), 32'd0);
        check_val("ar_hi_valid", 32'(out_valid), 32'd0);
        check_val("ar_hi_data", out_data, 32'h0);
        rst = 1'b1;
        tick();
        tick();
        check_val("ar_hi_quiet", 32'(out_valid), 32'd0);
        check_val("ar_hi_quiet_busy", 32'(busy), 32'd0);
        // Low-looking word after reset is treated as a fresh ZERO word
        drive(1'b1, 2'b01, 16'h2222);
        tick();
        check_val("ar_hi_fresh", out_data, 32'h00002222);

        // Async reset with a result pending
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 16'h8001);
        tick();
        check_val("ar_pend_pre", out_data, 32'h00002222);
        drive(1'b0, 2'b00, 16'h0000);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 16'h8001);
        tick();
        drive(1'b0, 2'b00, 16'h0000);
        check_val("ar_pend_data_pre", out_data, 32'hFFFF8001);
        #2 rst = 1'b0;
        #1;
        check_val("ar_pend_valid", 32'(out_valid), 32'd0);
        check_val("ar_pend_data", out_data, 32'h0);
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        check_val("ar_pend_quiet", 32'(out_valid), 32'd0);
        check_val("ar_pend_ready", 32'(in_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imm_extend_unit.md
IMM_EXTEND_UNIT -- requirements
Module: imm_extend_unit

Interface
REQ-001 The parameter IN_W SHALL default to 16 and SHALL set the width of the immediate word.
REQ-002 The parameter OUT_W SHALL default to 32, SHALL set the width of the extended result, and SHALL satisfy OUT_W >= 2*IN_W (elaboration error otherwise).
REQ-003 The port clk SHALL be an input, 1 bit wide: the single clock; all state SHALL update on its rising edge.
REQ-004 The port rst SHALL be an input, 1 bit wide, asynchronous and active-low.
REQ-005 The port flush SHALL be an input, 1 bit wide: a synchronous abort of all in-flight work.
REQ-006 The port in_valid SHALL be an input, 1 bit wide: in_word and in_mode are valid.
REQ-007 The port in_ready SHALL be an output, 1 bit wide: the block accepts a word this cycle.
REQ-008 The port in_word SHALL be an input, IN_W bits wide: the immediate word.
REQ-009 The port in_mode SHALL be an input, 2 bits wide, encoded as follows.
- 00 = SIGN
- 01 = ZERO
- 10 = UPPER
- 11 = CONCAT (two-word).
REQ-010 The port out_valid SHALL be an output, 1 bit wide: out_data holds a result.
REQ-011 The port out_ready SHALL be an input, 1 bit wide: the consumer takes out_data.
REQ-012 The port out_data SHALL be an output, OUT_W bits wide: the extended immediate.
REQ-013 The port busy SHALL be an output, 1 bit wide, high while a CONCAT high word is held.

Function
REQ-014 A word SHALL be accepted only on a cycle with in_valid && in_ready; in_ready SHALL equal (!out_valid || out_ready) && !flush.
REQ-015 The FSM SHALL have exactly two states, IDLE and HI_HELD; busy SHALL be 1 exactly in HI_HELD.
REQ-016 In IDLE, an accepted word with mode SIGN SHALL load out_data = in_word sign-extended from bit IN_W-1 to OUT_W bits.
REQ-017 In IDLE, an accepted word with mode ZERO SHALL load out_data = in_word zero-extended to OUT_W bits.
REQ-018 In IDLE, an accepted word with mode UPPER SHALL load out_data = {in_word, IN_W zeros}, sign-extended from bit 2*IN_W-1 to OUT_W bits.
REQ-019 For modes SIGN, ZERO and UPPER, out_valid SHALL be set on the clock edge that accepts the word (latency 1 cycle), and the FSM SHALL stay in IDLE.
REQ-020 In IDLE, an accepted CONCAT word SHALL be captured as the high word, the FSM SHALL go to HI_HELD, and out_valid SHALL not be set by this word.
REQ-021 In HI_HELD, the next accepted word SHALL be the low word, and its in_mode SHALL be ignored.
- out_data SHALL load {high, low}, sign-extended from bit 2*IN_W-1 to OUT_W bits.
- out_valid SHALL be set.
- The FSM SHALL return to IDLE.
REQ-022 While out_valid && !out_ready, out_data and out_valid SHALL stay stable.
REQ-023 If out_valid && out_ready with no accept that cycle, out_valid SHALL clear on the next edge.
REQ-024 If an output handshake and a result-producing accept occur in the same cycle, out_data SHALL take the new result and out_valid SHALL remain 1 (full throughput, one result per cycle).
REQ-025 If an output handshake coincides with the accept of a CONCAT high word, out_valid SHALL clear and the FSM SHALL go to HI_HELD.
REQ-026 In HI_HELD with no accepted word, the held high word SHALL be retained indefinitely.
REQ-027 flush SHALL take priority over every other event.
- On the next edge: FSM = IDLE, out_valid = 0, held high word discarded.
- out_data SHALL be unchanged.
REQ-028 in_valid with in_ready = 0 SHALL cause no state change; the producer SHALL hold its word.

Reset
REQ-029 Assertion of rst (low) SHALL immediately, without a clock, force the following.
- FSM = IDLE.
- out_valid = 0, busy = 0.
- out_data = 0, held high word = 0.
REQ-030 Reset asserted in HI_HELD or with out_valid = 1 SHALL discard the held word or pending result; no output SHALL appear after deassertion without new input.
REQ-031 After rst deasserts, in_ready SHALL be 1 (when flush = 0) from the first clock.

Verification (IN_W=16, OUT_W=32)
REQ-032 SIGN 16'h8001, out_ready=1 -> out_data 32'hFFFF8001 with out_valid one cycle later; ZERO 16'h8001 -> 32'h00008001.
REQ-033 UPPER 16'h1234 -> 32'h12340000.
REQ-034 CONCAT 16'hDEAD then a low word 16'hBEEF with mode 01 -> busy=1 between the two words, single result 32'hDEADBEEF, mode of the second word ignored.
REQ-035 Back-pressure: result pending with out_ready=0 for 3 cycles.
- in_ready SHALL be 0 and out_data stable for those cycles.
- When out_ready rises together with a new SIGN 16'h0005, out_data SHALL become 32'h00000005 the next cycle, out_valid continuously 1.
REQ-036 flush in HI_HELD after CONCAT 16'hAAAA -> IDLE, busy=0, out_valid=0; a following ZERO 16'h0001 yields 32'h00000001.
REQ-037 rst low asynchronously mid-CONCAT and with a result pending -> out_valid=0, busy=0, out_data=0 before the next edge.
